// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle for the data-memory load/store unit.
// The core is master; the LSU is slave.
interface dmem_lsu_if #(
  parameter int AW = 11
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [63:0]   req_cmp;
  logic          resp_valid;
  logic [63:0]   resp_data;

  modport master (
    output req_valid, req_op, req_size,
    output req_signed, req_addr,
    output req_wdata, req_cmp,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_size,
    input  req_signed, req_addr,
    input  req_wdata, req_cmp,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dmem_lsu.sv
// Big-endian load/store/cswap client for a 64-bit byte-enabled memory
// with one-cycle registered read latency.
module dmem_lsu #(
  parameter int AW = 11,
  parameter int DW = 64
) (
  input  logic          clock,
  input  logic          reset,
  dmem_lsu_if.slave     core,
  output logic [7:0]    mem_rdaddress,
  input  logic [DW-1:0] mem_q,
  output logic [7:0]    mem_wraddress,
  output logic [7:0]    mem_byteena,
  output logic          mem_wren,
  output logic [DW-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    LD_DATA,
    CS_READ
  } state_t;

  state_t      state_q, state_d;
  logic        resp_v_q, resp_v_d;
  logic [63:0] resp_q, resp_d;
  logic [7:0]  rd_hold;
  logic        rd_en;

  logic [7:0]  st_idx;
  logic [1:0]  st_size;
  logic [2:0]  st_off;
  logic        st_sgn;
  logic [63:0] st_wdata;
  logic [63:0] st_cmp;

  function automatic logic [2:0] align(
    input logic [2:0] a, input logic [1:0] s);
    case (s)
      2'd0:    align = a;
      2'd1:    align = a & 3'b110;
      2'd2:    align = a & 3'b100;
      default: align = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] lane_en(
    input logic [1:0] s, input logic [2:0] o);
    logic [7:0] base;
    case (s)
      2'd0:    base = 8'h80;
      2'd1:    base = 8'hC0;
      2'd2:    base = 8'hF0;
      default: base = 8'hFF;
    endcase
    lane_en = base >> o;
  endfunction

  // bit distance from the access's lowest lane up to its big-endian slot
  function automatic logic [5:0] lane_sh(
    input logic [1:0] s, input logic [2:0] o);
    logic [3:0] n;
    logic [3:0] t;
    n = 4'd1 << s;
    t = 4'd8 - n - {1'b0, o};
    lane_sh = {t[2:0], 3'b000};
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  endfunction

  logic [7:0]  idx;
  logic [1:0]  sz;
  logic [2:0]  off;
  logic        acc;
  logic        is_ld, is_st, is_cs, is_rsv;
  logic [63:0] ld_raw, ld_val;
  logic        ld_msb;
  logic        hit;

  assign idx    = 8'(core.req_addr[AW-1:3]);
  assign is_ld  = core.req_op == 2'd0;
  assign is_st  = core.req_op == 2'd1;
  assign is_cs  = core.req_op == 2'd2;
  assign is_rsv = core.req_op == 2'd3;
  assign sz     = is_cs ? 2'd3 : core.req_size;
  assign off    = align(core.req_addr[2:0], sz);

  assign core.req_ready  = (state_q == IDLE) & ~reset;
  assign core.resp_valid = resp_v_q;
  assign core.resp_data  = resp_q;
  assign acc = core.req_valid & core.req_ready;

  assign ld_raw = (mem_q >> lane_sh(st_size, st_off))
                & size_mask(st_size);
  always_comb begin
    case (st_size)
      2'd0:    ld_msb = ld_raw[7];
      2'd1:    ld_msb = ld_raw[15];
      2'd2:    ld_msb = ld_raw[31];
      default: ld_msb = ld_raw[63];
    endcase
  end
  assign ld_val = (st_sgn & ld_msb)
                ? (ld_raw | ~size_mask(st_size)) : ld_raw;
  assign hit = mem_q == st_cmp;

  assign mem_rdaddress = rd_en ? idx : rd_hold;

  always_comb begin
    state_d       = state_q;
    resp_v_d      = 1'b0;
    resp_d        = resp_q;
    rd_en         = 1'b0;
    mem_wren      = 1'b0;
    mem_byteena   = 8'h00;
    mem_wraddress = st_idx;
    mem_data      = '0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            is_ld: begin
              rd_en   = 1'b1;
              state_d = LD_DATA;
            end
            is_st: begin
              mem_wren      = 1'b1;
              mem_byteena   = lane_en(sz, off);
              mem_wraddress = idx;
              mem_data      = (core.req_wdata & size_mask(sz))
                            << lane_sh(sz, off);
              resp_v_d      = 1'b1;
              resp_d        = '0;
            end
            is_cs: begin
              rd_en   = 1'b1;
              state_d = CS_READ;
            end
            is_rsv: begin
              resp_v_d = 1'b1;
              resp_d   = '0;
            end
          endcase
        end
      end
      LD_DATA: begin
        state_d  = IDLE;
        resp_v_d = 1'b1;
        resp_d   = ld_val;
      end
      CS_READ: begin
        state_d  = IDLE;
        resp_v_d = 1'b1;
        resp_d   = {63'd0, hit};
        if (hit) begin
          mem_wren    = 1'b1;
          mem_byteena = 8'hFF;
          mem_data    = st_wdata;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d     = IDLE;
      resp_v_d    = 1'b0;
      resp_d      = '0;
      mem_wren    = 1'b0;
      mem_byteena = 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    state_q  <= state_d;
    resp_v_q <= resp_v_d;
    resp_q   <= resp_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_hold  <= '0;
      st_idx   <= '0;
      st_size  <= '0;
      st_off   <= '0;
      st_sgn   <= 1'b0;
      st_wdata <= '0;
      st_cmp   <= '0;
    end else if (acc) begin
      if (rd_en) rd_hold <= idx;
      st_idx   <= idx;
      st_size  <= sz;
      st_off   <= off;
      st_sgn   <= core.req_signed & ~is_cs;
      st_wdata <= core.req_wdata;
      st_cmp   <= core.req_cmp;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a registered-read
// byte-enabled 256x64 memory model.
module tb_dmem_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_clr;
  logic [7:0]  mem_rdaddress, mem_wraddress, mem_byteena;
  logic        mem_wren;
  logic [63:0] mem_q, mem_data;
  logic [63:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_lsu_if #(.AW(11)) bus ();

  dmem_lsu #(.AW(11), .DW(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .core          (bus.slave),
    .mem_rdaddress (mem_rdaddress),
    .mem_q         (mem_q),
    .mem_wraddress (mem_wraddress),
    .mem_byteena   (mem_byteena),
    .mem_wren      (mem_wren),
    .mem_data      (mem_data)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++)
      m[63-8*b -: 8] = {8{be[7-b]}};
    return m;
  endfunction

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      mem_q <= mem[mem_rdaddress];
      if (mem_wren)
        mem[mem_wraddress] <=
          (mem[mem_wraddress] & ~be_mask(mem_byteena))
          | (mem_data & be_mask(mem_byteena));
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic        a_wren, c_wren;
  logic [7:0]  a_be, c_be, a_wa, c_wa, a_ra;
  logic [63:0] a_data, c_data, r_data;

  task automatic do_req(input string tag,
                        input logic [1:0] op,
                        input logic [1:0] sz,
                        input logic sg,
                        input logic [10:0] addr,
                        input logic [63:0] wd,
                        input logic [63:0] cm,
                        input int lat);
    @(negedge clock);
    bus.req_op     = op;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_cmp    = cm;
    bus.req_valid  = 1'b1;
    #1;
    check({tag, "_rdy"}, bus.req_ready, 1);
    a_wren = mem_wren;
    a_be   = mem_byteena;
    a_wa   = mem_wraddress;
    a_data = mem_data;
    a_ra   = mem_rdaddress;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    #1;
    c_wren = mem_wren;
    c_be   = mem_byteena;
    c_wa   = mem_wraddress;
    c_data = mem_data;
    if (lat == 1) begin
      check({tag, "_rv"}, bus.resp_valid, 1);
    end else begin
      check({tag, "_rv_early"}, bus.resp_valid, 0);
      @(posedge clock);
      #2 check({tag, "_rv"}, bus.resp_valid, 1);
    end
    r_data = bus.resp_data;
    @(posedge clock);
    #2 check({tag, "_rv_once"}, bus.resp_valid, 0);
  endtask

  logic [9:0]  rdy_bits, rv_bits;
  logic [63:0] rq [$];
  int          sidx;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_cmp    = '0;
    reset   = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rv", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_data, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_be", mem_byteena, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    mem_clr = 1'b0;
    #1 check("post_rst_ready", bus.req_ready, 1);

    do_req("st_octa", 2'd1, 2'd3, 1'b0, 11'h008,
           64'h0123_4567_89AB_CDEF, 0, 1);
    check("st_octa_wren", a_wren, 1);
    check("st_octa_be", a_be, 8'hFF);
    check("st_octa_wa", a_wa, 8'd1);
    check("st_octa_data", a_data, 64'h0123_4567_89AB_CDEF);
    check("st_octa_resp", r_data, 0);

    do_req("ld_tetra", 2'd0, 2'd2, 1'b0, 11'h00C, 0, 0, 2);
    check("ld_tetra_ra", a_ra, 8'd1);
    check("ld_tetra_wren", a_wren, 0);
    check("ld_tetra_data", r_data, 64'h89AB_CDEF);
    do_req("ld_byte_s", 2'd0, 2'd0, 1'b1, 11'h00C, 0, 0, 2);
    check("ld_byte_s_data", r_data, 64'hFFFF_FFFF_FFFF_FF89);
    do_req("ld_wyde", 2'd0, 2'd1, 1'b0, 11'h00A, 0, 0, 2);
    check("ld_wyde_data", r_data, 64'h4567);

    do_req("st_byte", 2'd1, 2'd0, 1'b0, 11'h013,
           64'hFFFF_FFFF_FFFF_FFAA, 0, 1);
    check("st_byte_be", a_be, 8'h10);
    check("st_byte_wa", a_wa, 8'd2);
    check("st_byte_data", a_data, 64'h0000_00AA_0000_0000);
    do_req("st_wyde", 2'd1, 2'd1, 1'b0, 11'h017, 64'hBEEF, 0, 1);
    check("st_wyde_be", a_be, 8'h03);
    check("st_wyde_data", a_data, 64'h0000_0000_0000_BEEF);
    do_req("ld_mix", 2'd0, 2'd3, 1'b0, 11'h010, 0, 0, 2);
    check("ld_mix_data", r_data, 64'h0000_00AA_0000_BEEF);

    do_req("st_five", 2'd1, 2'd3, 1'b0, 11'h020, 64'd5, 0, 1);
    do_req("cs_hit", 2'd2, 2'd0, 1'b1, 11'h023, 64'd9, 64'd5, 2);
    check("cs_hit_acc_wren", a_wren, 0);
    check("cs_hit_wren", c_wren, 1);
    check("cs_hit_be", c_be, 8'hFF);
    check("cs_hit_wa", c_wa, 8'd4);
    check("cs_hit_wdata", c_data, 64'd9);
    check("cs_hit_resp", r_data, 1);
    do_req("cs_miss", 2'd2, 2'd3, 1'b0, 11'h020, 64'd7, 64'd5, 2);
    check("cs_miss_acc_wren", a_wren, 0);
    check("cs_miss_wren", c_wren, 0);
    check("cs_miss_resp", r_data, 0);
    do_req("ld_cs", 2'd0, 2'd3, 1'b0, 11'h020, 0, 0, 2);
    check("ld_cs_data", r_data, 64'd9);

    sidx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (sidx < 6) begin
        bus.req_valid  = 1'b1;
        bus.req_size   = 2'd3;
        bus.req_signed = 1'b0;
        if (sidx < 4) begin
          bus.req_op    = 2'd1;
          bus.req_addr  = 11'(32'h040 + 8 * sidx);
          bus.req_wdata = 64'hA0A0_0000_0000_0000 | 64'(sidx);
        end else begin
          bus.req_op   = 2'd0;
          bus.req_addr = 11'(32'h040 + 8 * (sidx - 4));
        end
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      rdy_bits[c] = bus.req_ready;
      rv_bits[c]  = bus.resp_valid;
      if (bus.resp_valid) rq.push_back(bus.resp_data);
      @(posedge clock);
      if (bus.req_valid && rdy_bits[c]) sidx++;
    end
    check("hs_ready_pattern", rdy_bits, 10'h35F);
    check("hs_rv_pattern", rv_bits, 10'h15E);
    check("hs_n_resp", rq.size(), 6);
    if (rq.size() == 6) begin
      check("hs_st_resp", rq[0], 0);
      check("hs_ld0", rq[4], 64'hA0A0_0000_0000_0000);
      check("hs_ld1", rq[5], 64'hA0A0_0000_0000_0001);
    end

    @(negedge clock);
    bus.req_op    = 2'd2;
    bus.req_addr  = 11'h020;
    bus.req_wdata = 64'h77;
    bus.req_cmp   = 64'd9;
    bus.req_valid = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    #1 check("rcs_wren", mem_wren, 0);
    check("rcs_ready", bus.req_ready, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check("rcs_rv", bus.resp_valid, 0);
    check("rcs_ready_after", bus.req_ready, 1);
    @(posedge clock);
    #2 check("rcs_rv_late", bus.resp_valid, 0);
    check("rcs_mem", mem[4], 64'd9);
    do_req("ld_rcs", 2'd0, 2'd3, 1'b0, 11'h020, 0, 0, 2);
    check("ld_rcs_data", r_data, 64'd9);

    do_req("rsv", 2'd3, 2'd3, 1'b0, 11'h028, 64'hDEAD, 0, 1);
    check("rsv_wren", a_wren, 0);
    check("rsv_resp", r_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end
endmodule
